sync_fifo_core: RTL and testbench
=================================

// Module: sync_fifo_core
// PURPOSE
//   Single-clock first-in/first-out buffer with registered read data and full/empty status.
//   Decouples a producer and a consumer that share clk in the same clock domain.
//   Storage is a register array indexed by wrap-around read/write pointers.
// PARAMETERS
//   DATA_WIDTH  32  width of each stored word, in bits (>=1)
//   FIFO_DEPTH  16  number of entries; must be a power of two, >=2
// PORTS
//   clk       in   1                       clock; all state updates on the rising edge
//   rst_n     in   1                       asynchronous active-low reset
//   wr_en     in   1                       write request; data_in is pushed when accepted
//   rd_en     in   1                       read request; the head word is popped when accepted
//   data_in   in   DATA_WIDTH              write data, sampled at the rising edge
//   data_out  out  DATA_WIDTH              registered read data
//   empty     out  1                       1 = no words stored
//   full      out  1                       1 = FIFO_DEPTH words stored
//   count     out  $clog2(FIFO_DEPTH)+1    current occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
// - Reset (rst_n=0, takes effect immediately, independent of clk):
//   - wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0.
//   - Storage array is not cleared.
//   - Reset asserted mid-operation discards all contents.
// - Pointers:
//   - $clog2(FIFO_DEPTH)+1 bits wide (one extra wrap bit).
//   - Address = low bits; each pointer wraps from FIFO_DEPTH-1 to 0.
//   - empty = (wr_ptr == rd_ptr).
//   - full = low bits equal and wrap bits differ.
//   - count = wr_ptr - rd_ptr, modulo 2^(ptr width).
//   - empty, full and count are combinational from the registered pointers.
// - Write acceptance: wr_en && !full.
//   - On an accepted write, mem[wr_ptr] <= data_in and wr_ptr increments.
//   - A write while full is dropped; no state changes and no error flag.
// - Read acceptance: rd_en && !empty.
//   - On an accepted read, data_out <= mem[rd_ptr] and rd_ptr increments.
//   - Latency: data_out is valid immediately after the same rising edge that accepts the read.
//   - A read while empty is ignored; data_out holds its last value.
// - data_out changes only on accepted reads; otherwise it holds its value.
// - Simultaneous wr_en and rd_en:
//   - Each request is judged independently on the pre-edge flags.
//   - Neither empty nor full: both accepted, count unchanged.
//   - Empty: only the write is accepted; the new word is not read-through.
//     empty deasserts after the edge.
//   - Full: only the read is accepted; the write is dropped. full deasserts after the edge.
// - Ordering: words are returned in exact write order with no loss, duplication or corruption.
// - No combinational path from any input to any output.
// TESTING
// 1. Reset: assert rst_n=0 mid-run with count=5.
//    -> immediately empty=1, full=0, count=0, data_out=0.
//    -> a subsequent read with rd_en=1 leaves data_out=0.
// 2. Fill and drain:
//    -> write 16 words 0x1000_0000+i: full=1 and count=16 after the 16th write.
//    -> a 17th write of 0xDEAD_BEEF is dropped.
//    -> 16 reads return 0x1000_0000..0x1000_000F in order; then empty=1.
// 3. Underflow: on an empty FIFO, pulse rd_en for 3 cycles.
//    -> data_out keeps its prior value; count stays 0; pointers unchanged.
// 4. Simultaneous access with count=4: assert wr_en=rd_en=1 for 10 cycles.
//    -> count stays 4; read data matches write order.
//    -> both pointers wrap past index 15.
// 5. Boundary simultaneous access:
//    -> when empty with wr_en=rd_en=1: count becomes 1, data_out unchanged.
//    -> when full with wr_en=rd_en=1: count becomes 15; the written word is absent from later reads.
// 6. Random traffic: 20 writes of random data with random wr_en/rd_en.
//    -> a scoreboard queue matches every data_out.
//    -> empty/full/count agree with the model every cycle.

Source files
------------

// File: rtl/sync_fifo_core.sv
// ----------------------------------------------------------------------------
// sync_fifo_core
//   Single-clock FIFO built on a register array with wrap-around read/write
//   pointers. Read data is registered: an accepted read updates data_out on the
//   same rising edge that pops the word.
//
// Ports
//   clk       rising-edge clock for all state
//   rst_n     asynchronous active-low reset (pointers and data_out only)
//   wr_en     write request, data_in pushed when accepted
//   rd_en     read request, head word popped into data_out when accepted
//   data_in   write data, sampled at the rising edge
//   data_out  registered read data, changes only on accepted reads
//   empty     no words stored
//   full      FIFO_DEPTH words stored
//   count     current occupancy, 0..FIFO_DEPTH
//
// Request semantics: wr_en/rd_en are requests and ~full/~empty act as the
// matching ready signals. A transfer happens on a rising edge where the request
// is high and its ready was high just before that edge. Rejected requests
// (write while full, read while empty) are silently dropped. Both requests are
// judged on the pre-edge flags, so a write into an empty FIFO is never read
// through in the same cycle.
// ----------------------------------------------------------------------------
module sync_fifo_core #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit above the address bits so that
    // full and empty can be told apart when the address bits match.
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic wr_accept;
    logic rd_accept;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count     = wr_ptr - rd_ptr;

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // Storage is deliberately left out of reset; only the pointers define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                // Read and write never target the same live entry in one
                // cycle: that would need both accepted while empty or full.
                data_out <= mem[rd_ptr[AW-1:0]];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_core.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_core
//   Self-checking bench for sync_fifo_core (DATA_WIDTH=32, FIFO_DEPTH=16).
//   A queue holds the words the FIFO should contain; model_dout holds the
//   value data_out should show.
// ----------------------------------------------------------------------------
module tb_sync_fifo_core;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic [4:0]    count;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_dout;
    int            n_tests;
    int            n_fail;

    sync_fifo_core #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .count    (count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge. Drives one cycle of requests, updates
    // the model at the rising edge, checks all outputs 1 time unit later and
    // returns after the next falling edge with requests idle.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        int   pre;
        logic wacc;
        logic racc;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        pre  = exp_q.size();
        wacc = w && (pre < DEPTH);
        racc = r && (pre > 0);
        @(posedge clk);
        if (racc) model_dout = exp_q.pop_front();
        if (wacc) exp_q.push_back(d);
        #1;
        check_eq({tag, ":data_out"}, data_out, model_dout);
        check_eq({tag, ":count"}, DW'(count), DW'(exp_q.size()));
        check_eq({tag, ":empty"}, DW'(empty), DW'(exp_q.size() == 0));
        check_eq({tag, ":full"}, DW'(full), DW'(exp_q.size() == DEPTH));
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        int writes;
        int budget;
        n_tests    = 0;
        n_fail     = 0;
        model_dout = '0;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        data_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("por:empty", DW'(empty), 1);
        check_eq("por:count", DW'(count), 0);
        check_eq("por:data_out", data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- 1. reset mid-run with count=5 ----
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'hA500_0000 + i, "rst_fill");
        step(1'b0, 1'b1, '0, "rst_rd");
        check_eq("rst:pre_count", DW'(count), 5);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_dout = '0;
        check_eq("rst:empty", DW'(empty), 1);
        check_eq("rst:full", DW'(full), 0);
        check_eq("rst:count", DW'(count), 0);
        check_eq("rst:data_out", data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1'b0, 1'b1, '0, "rst_underflow");

        // ---- 2. fill and drain ----
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'h1000_0000 + i, "fill");
        check_eq("fill:full16", DW'(full), 1);
        check_eq("fill:count16", DW'(count), 16);
        step(1'b1, 1'b0, 32'hDEAD_BEEF, "overflow");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, "drain");
        check_eq("drain:last", data_out, 32'h1000_000F);
        check_eq("drain:empty", DW'(empty), 1);

        // ---- 3. underflow ----
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, "underflow");

        // ---- 4. simultaneous access at count=4, pointers crossing index 15 ----
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h2000_0000 + i, "pre_wr");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0, "pre_rd");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h3000_0000 + i, "sim_fill");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'h3000_0004 + i, "sim_rw");
        check_eq("sim:count4", DW'(count), 4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, "sim_drain");
        check_eq("sim:last", data_out, 32'h3000_000D);

        // ---- 5. boundary simultaneous access ----
        step(1'b1, 1'b1, 32'h4000_0001, "empty_rw");
        check_eq("empty_rw:count1", DW'(count), 1);
        check_eq("empty_rw:dout_hold", data_out, 32'h3000_000D);
        step(1'b0, 1'b1, '0, "empty_rw_drain");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'h5000_0000 + i, "full_fill");
        step(1'b1, 1'b1, 32'hBAD0_0000, "full_rw");
        check_eq("full_rw:count15", DW'(count), 15);
        check_eq("full_rw:dout", data_out, 32'h5000_0000);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, '0, "full_rw_drain");
        check_eq("full_rw:empty", DW'(empty), 1);

        // ---- 6. random traffic ----
        writes = 0;
        budget = 0;
        while (writes < 20 && budget < 500) begin
            logic w;
            logic r;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (w) writes++;
            step(w, r, $urandom, "rand");
            budget++;
        end
        if (writes < 20) check_eq("rand:budget", DW'(writes), 20);
        budget = 0;
        while (exp_q.size() > 0 && budget < 40) begin
            step(1'b0, 1'b1, '0, "rand_drain");
            budget++;
        end
        check_eq("rand:final_empty", DW'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
